uac_in_ep_scheduler: RTL
========================

// Module: uac_in_ep_scheduler
// PURPOSE
//  Schedules the isochronous IN (microphone) endpoints EP1..EP3 onto the single USB TX path.
//  Once per SOF it computes each endpoint's packet length from a fractional samples-per-frame rate.
//  When the USB core opens an IN transaction, it muxes that endpoint's first-word-fall-through (FWFT)
//  capture FIFO onto o_usb_txdat.
//  Sits between the per-mic capture FIFOs and the USB device core TX handshake.
// PARAMETERS
//  NUM_EP        3     number of IN endpoints; slot k serves endpoint k+1
//  SAMPLE_BYTES  4     bytes per audio frame (all channels), 1..8
//  LEN_W         12    width of packet length and FIFO level
// PORTS
//  i_clk60           in   1              60 MHz USB clock; only clock
//  i_reset_n         in   1              synchronous, active-low reset
//  i_usb_busreset    in   1              USB bus reset; same effect as reset
//  i_usb_sof         in   1              one-cycle SOF strobe
//  i_usb_endpt_sel   in   4              endpoint currently addressed by the core
//  i_usb_txact       in   1              IN transaction active
//  i_usb_txpop       in   1              core consumes o_usb_txdat this cycle
//  i_usb_txpktfin    in   1              one-cycle pulse: IN packet finished
//  i_ep_active       in   NUM_EP         per slot: streaming alternate setting (alt != 0)
//  i_ep_spf_int      in   NUM_EP*8       per slot: integer samples per frame
//  i_ep_spf_frac     in   NUM_EP*16      per slot: fractional samples per frame (/65536)
//  i_ep_fifo_level   in   NUM_EP*LEN_W   per slot: bytes held in the capture FIFO
//  i_ep_fifo_dat     in   NUM_EP*8       per slot: FWFT FIFO head byte
//  o_ep_fifo_rd      out  NUM_EP         per slot: FIFO pop
//  o_usb_txval       out  1              TX byte valid
//  o_usb_txdat       out  8              TX byte
//  o_usb_txdat_len   out  LEN_W          packet length for the selected endpoint
//  o_usb_txcork      out  1              1 = NAK/hold the selected endpoint
//  o_ep_underrun     out  NUM_EP         sticky: a zero-length packet was sent for lack of data
// BEHAVIOUR
//  Reset / busreset (either): outputs 0, o_usb_txcork=1; all accumulators, lengths and flags cleared;
//   state IDLE. Reset asserted mid-packet aborts the packet immediately.
//  Per-slot rate generator, on i_usb_sof while i_ep_active[k]=1:
//   {carry, acc[15:0]} = acc + spf_frac
//   target = (spf_int + carry) * SAMPLE_BYTES, truncated to LEN_W bits
//   len_q[k] = target if fifo_level >= target, else 0 (zero-length packet, underrun[k] set)
//   primed[k]=1, sent[k]=0
//  i_ep_active[k]=0: acc, len_q, primed and sent of slot k are held at 0.
//   This takes effect after the current packet if slot k is in SEND.
//  SOF arriving while slot k is in SEND: the computation for slot k is saved in a pending register.
//   It is applied on the cycle after i_usb_txpktfin; the accumulator is still stepped exactly once.
//  Selected slot: sel_ok = i_usb_endpt_sel in 1..NUM_EP; k = sel-1.
//  o_usb_txdat_len (registered, 1-cycle latency from endpt_sel):
//   len_q[k] if sel_ok, primed[k] and !sent[k]; otherwise 0.
//  o_usb_txcork (registered): 1 if !sel_ok, !i_ep_active[k] or !primed[k]; otherwise 0.
//   An already-sent slot is not corked; it returns length 0.
//  FSM:
//   IDLE -> SEND on i_usb_txact & !cork. Latch k and len; cnt=0.
//   SEND: o_usb_txval = (cnt < len); o_usb_txdat = i_ep_fifo_dat[k] (combinational mux).
//    o_ep_fifo_rd[k] = i_usb_txpop & (cnt < len); cnt increments on each such pop.
//    Pops with cnt == len are ignored (no FIFO read).
//   SEND -> IDLE on i_usb_txpktfin: sent[k]=1, pending update applied.
//    Also SEND -> IDLE if i_usb_txact falls without pktfin: sent stays 0, so the host may retry.
//    Bytes already popped are lost and are not re-queued.
//  Only one slot is ever in SEND; o_ep_fifo_rd is one-hot or zero.
//  txact while corked: stays IDLE, txval=0.
//  sel change during SEND is ignored; the latched k is used until the FSM leaves SEND.
//  Lengths wrap modulo 2^LEN_W; the integrator keeps int*SAMPLE_BYTES < 2^LEN_W.
// TESTING
//  T1 48 kHz: int=48, frac=0, level=1000, EP1 active; 5 SOFs, each followed by an IN on EP1
//     -> txdat_len=192 each frame; exactly 192 fifo_rd pulses; bytes match FIFO order.
//  T2 44.1 kHz: int=44, frac=16'h199A; 10 SOFs -> frames 1..9 len=176, frame 10 len=180
//     (acc wraps to 4).
//  T3 Underrun: level=100, target=192 -> len=0, no fifo_rd, o_ep_underrun[0]=1 and stays 1
//     until reset.
//  T4 EP1 and EP2 active; IN EP2 then IN EP1 in the same frame -> correct one-hot fifo_rd;
//     a second IN on EP2 in that frame -> len 0; sel=4 -> cork=1.
//  T5 SOF mid-SEND on EP1 -> current packet keeps the old length;
//     the next frame's length appears one cycle after pktfin.
//  T6 i_reset_n=0 mid-SEND (and separately busreset) -> next cycle txval=0, fifo_rd=0, cork=1;
//     after release, the first IN before any SOF is corked.

Source files
------------

// File: rtl/uac_in_ep_scheduler.sv
// uac_in_ep_scheduler
// Multiplexes the isochronous IN (microphone) endpoints EP1..EP(NUM_EP) onto the
// single USB TX byte path. On every SOF each active slot steps a fractional
// samples-per-frame accumulator and computes that frame's packet length. When
// the USB core opens an IN transaction, the addressed slot's FWFT capture FIFO
// is streamed out byte by byte.
//
// TX handshake: a byte transfers in every cycle where o_usb_txval and
// i_usb_txpop are both high; that same cycle pulses o_ep_fifo_rd for the
// selected slot. i_usb_txpop without o_usb_txval is ignored, and o_usb_txval
// never depends on i_usb_txpop.

module uac_in_ep_scheduler #(
  parameter int NUM_EP       = 3,
  parameter int SAMPLE_BYTES = 4,
  parameter int LEN_W        = 12
) (
  input  logic                    i_clk60,
  input  logic                    i_reset_n,
  input  logic                    i_usb_busreset,
  input  logic                    i_usb_sof,
  input  logic [3:0]              i_usb_endpt_sel,
  input  logic                    i_usb_txact,
  input  logic                    i_usb_txpop,
  input  logic                    i_usb_txpktfin,
  input  logic [NUM_EP-1:0]       i_ep_active,
  input  logic [NUM_EP*8-1:0]     i_ep_spf_int,
  input  logic [NUM_EP*16-1:0]    i_ep_spf_frac,
  input  logic [NUM_EP*LEN_W-1:0] i_ep_fifo_level,
  input  logic [NUM_EP*8-1:0]     i_ep_fifo_dat,
  output logic [NUM_EP-1:0]       o_ep_fifo_rd,
  output logic                    o_usb_txval,
  output logic [7:0]              o_usb_txdat,
  output logic [LEN_W-1:0]        o_usb_txdat_len,
  output logic                    o_usb_txcork,
  output logic [NUM_EP-1:0]       o_ep_underrun,
  output logic                    o_dbg_state
);

  localparam int IDX_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  cur_k;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  sel_idx_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_lat;

  // Per-slot registered state
  logic [15:0]       acc_q      [NUM_EP];
  logic [LEN_W-1:0]  len_q      [NUM_EP];
  logic [LEN_W-1:0]  pend_len_q [NUM_EP];
  logic [NUM_EP-1:0] primed_q;
  logic [NUM_EP-1:0] sent_q;
  logic [NUM_EP-1:0] pend_q;
  logic [NUM_EP-1:0] underrun_q;

  // Per-slot unpacked inputs and rate computation
  logic [7:0]        spf_int    [NUM_EP];
  logic [15:0]       spf_frac   [NUM_EP];
  logic [LEN_W-1:0]  fifo_level [NUM_EP];
  logic [7:0]        fifo_dat   [NUM_EP];
  logic [16:0]       acc_sum    [NUM_EP];
  logic [LEN_W-1:0]  target     [NUM_EP];
  logic [LEN_W-1:0]  new_len    [NUM_EP];
  logic [NUM_EP-1:0] short_fr;
  logic [NUM_EP-1:0] step_en;
  logic [NUM_EP-1:0] in_send;

  logic              rst;
  logic              leave;
  logic              sel_ok;
  logic [LEN_W-1:0]  sel_len_now;
  logic              sel_cork_now;
  logic [LEN_W-1:0]  lat_len;
  logic              pop_ok;

  assign rst           = !i_reset_n || i_usb_busreset;
  assign o_ep_underrun = underrun_q;
  assign o_dbg_state   = (state == ST_SEND);

  // Unpack per-slot buses and compute each slot's length for the coming frame
  always_comb begin
    for (int k = 0; k < NUM_EP; k++) begin
      spf_int[k]    = i_ep_spf_int[k*8 +: 8];
      spf_frac[k]   = i_ep_spf_frac[k*16 +: 16];
      fifo_level[k] = i_ep_fifo_level[k*LEN_W +: LEN_W];
      fifo_dat[k]   = i_ep_fifo_dat[k*8 +: 8];
      acc_sum[k]    = {1'b0, acc_q[k]} + {1'b0, spf_frac[k]};
      // Carry out of the fractional accumulator adds one extra sample this frame
      target[k]     = LEN_W'((32'(spf_int[k]) + 32'(acc_sum[k][16])) * SAMPLE_BYTES);
      short_fr[k]   = (fifo_level[k] < target[k]);
      new_len[k]    = short_fr[k] ? '0 : target[k];
      step_en[k]    = i_usb_sof && i_ep_active[k];
      in_send[k]    = (state == ST_SEND) && (cur_k == IDX_W'(k));
    end
  end

  // Decode the addressed endpoint into length/cork for this cycle and for the latch
  always_comb begin
    sel_ok       = (i_usb_endpt_sel != 4'd0) && (32'(i_usb_endpt_sel) <= NUM_EP);
    sel_idx      = IDX_W'(i_usb_endpt_sel - 4'd1);
    sel_len_now  = '0;
    sel_cork_now = 1'b1;
    lat_len      = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      if (sel_ok && (sel_idx == IDX_W'(k))) begin
        sel_len_now  = (primed_q[k] && !sent_q[k]) ? len_q[k] : '0;
        sel_cork_now = !(i_ep_active[k] && primed_q[k]);
      end
      // An already-sent slot answers with a zero-length packet, not a NAK
      if (sel_idx_q == IDX_W'(k)) begin
        lat_len = (primed_q[k] && !sent_q[k]) ? len_q[k] : '0;
      end
    end
  end

  // TX datapath: valid while bytes remain, FIFO pop only on an accepted byte
  always_comb begin
    o_usb_txval  = (state == ST_SEND) && (cnt < len_lat);
    pop_ok       = o_usb_txval && i_usb_txpop && !rst;
    leave        = (state == ST_SEND) && (i_usb_txpktfin || !i_usb_txact);
    o_ep_fifo_rd = '0;
    o_usb_txdat  = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      if (in_send[k]) begin
        o_usb_txdat     = fifo_dat[k];
        o_ep_fifo_rd[k] = pop_ok;
      end
    end
  end

  // Selection registers, TX FSM and per-slot frame bookkeeping
  always_ff @(posedge i_clk60) begin
    if (rst) begin
      state           <= ST_IDLE;
      cur_k           <= '0;
      sel_idx_q       <= '0;
      cnt             <= '0;
      len_lat         <= '0;
      o_usb_txdat_len <= '0;
      o_usb_txcork    <= 1'b1;
      primed_q        <= '0;
      sent_q          <= '0;
      pend_q          <= '0;
      underrun_q      <= '0;
      for (int k = 0; k < NUM_EP; k++) begin
        acc_q[k]      <= '0;
        len_q[k]      <= '0;
        pend_len_q[k] <= '0;
      end
    end else begin
      sel_idx_q       <= sel_idx;
      o_usb_txdat_len <= sel_len_now;
      o_usb_txcork    <= sel_cork_now;

      case (state)
        ST_IDLE: begin
          if (i_usb_txact && !o_usb_txcork) begin
            state   <= ST_SEND;
            cur_k   <= sel_idx_q;
            len_lat <= lat_len;
            cnt     <= '0;
          end
        end
        ST_SEND: begin
          if (pop_ok) begin
            cnt <= cnt + LEN_W'(1);
          end
          if (leave) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      for (int k = 0; k < NUM_EP; k++) begin
        if (step_en[k] && short_fr[k]) begin
          underrun_q[k] <= 1'b1;
        end
        if (!i_ep_active[k] && !in_send[k]) begin
          // Inactive slot is parked; deactivation waits for the packet to end
          acc_q[k]    <= '0;
          len_q[k]    <= '0;
          primed_q[k] <= 1'b0;
          sent_q[k]   <= 1'b0;
          pend_q[k]   <= 1'b0;
        end else begin
          if (step_en[k]) begin
            acc_q[k] <= acc_sum[k][15:0];
          end
          if (!in_send[k]) begin
            if (step_en[k]) begin
              len_q[k]    <= new_len[k];
              primed_q[k] <= 1'b1;
              sent_q[k]   <= 1'b0;
            end
          end else if (!leave) begin
            // Packet in flight keeps its length; park the new frame's result
            if (step_en[k]) begin
              pend_q[k]     <= 1'b1;
              pend_len_q[k] <= new_len[k];
            end
          end else if (step_en[k]) begin
            len_q[k]    <= new_len[k];
            primed_q[k] <= 1'b1;
            sent_q[k]   <= 1'b0;
            pend_q[k]   <= 1'b0;
          end else if (pend_q[k]) begin
            len_q[k]    <= pend_len_q[k];
            primed_q[k] <= 1'b1;
            sent_q[k]   <= 1'b0;
            pend_q[k]   <= 1'b0;
          end else if (i_usb_txpktfin) begin
            // Abort (txact drop) leaves sent clear so the host may retry
            sent_q[k] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
